// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state encoding and default operand width for the sequential multiplier
package mult_pkg;
    localparam int N_PADRAO = 4;
    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        CALC   = 2'b01,
        FIM    = 2'b10
    } estado_t;
endpackage

// File: rtl/etapa_multiplicacao.sv
// etapa_multiplicacao: one shift-and-add step, conditional add of MCAND then right shift of {C,ACC,Q}
module etapa_multiplicacao #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_acc,
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_mcand,
    output logic [N-1:0] o_acc,
    output logic [N-1:0] o_q
);
    logic [N:0] w_soma;
    assign w_soma = i_q[0] ? {1'b0, i_acc} + {1'b0, i_mcand} : {1'b0, i_acc};
    assign o_acc  = w_soma[N:1];
    assign o_q    = {w_soma[0], i_q[N-1:1]};
endmodule

// File: rtl/multiplicador_sequencial.sv
// multiplicador_sequencial: unsigned N x N shift-and-add multiplier with start/busy/done handshake
module multiplicador_sequencial
    import mult_pkg::*;
#(
    parameter int N = N_PADRAO
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_p,
    output logic           o_busy,
    output logic           o_done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    estado_t        r_estado, w_prox;
    logic [N-1:0]   r_mcand, r_acc, r_q, w_acc, w_q;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_p;
    logic           r_busy, r_done, w_ultimo;
    etapa_multiplicacao #(.N(N)) u_etapa (
        .i_acc   (r_acc),
        .i_q     (r_q),
        .i_mcand (r_mcand),
        .o_acc   (w_acc),
        .o_q     (w_q)
    );
    assign w_ultimo = r_cnt == CW'(N - 1);
    always_comb begin
        w_prox = (r_estado == CALC) ? (w_ultimo ? FIM : CALC) : (i_start ? CALC : OCIOSO);
    end
    // The carry is consumed by the shift within the step, so it never needs to be held.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_estado <= OCIOSO;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_busy   <= w_prox == CALC;
            r_done   <= w_prox == FIM;
            if (r_estado == CALC) begin
                r_acc <= w_acc;
                r_q   <= w_q;
                r_cnt <= r_cnt + CW'(1);
                if (w_ultimo) r_p <= {w_acc, w_q};
            end else if (i_start) begin
                r_mcand <= i_a;
                r_q     <= i_b;
                r_acc   <= '0;
                r_cnt   <= '0;
            end
        end
    end
    assign o_p    = r_p;
    assign o_busy = r_busy;
    assign o_done = r_done;
endmodule
